// File: rtl/asip_fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Widths here are 32 bits; users cast to their own N.
package asip_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fetch_state_t;

   localparam logic [31:0] NOP          = 32'h0000_0000;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] INST_STEP    = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, instruction} entries for the fetch queue.
// Flush wins over push and pop; head reads straight from storage.
module fetch_fifo
   import asip_fetch_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [2*N-1:0]           data_in,
   output logic [2*N-1:0]           data_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [2*N-1:0] mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clock) begin
      if (push && !flush)
         mem[wr_ptr] <= data_in;
   end

   assign data_out = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: one-outstanding-request memory port
// feeding a small queue toward decode, with redirect handling.
module inst_fetch_queue
   import asip_fetch_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   redirect,
   input  logic [N-1:0]           redirect_addr,
   input  logic                   stall,
   output logic                   mem_req,
   output logic [N-1:0]           mem_addr,
   input  logic                   mem_ack,
   input  logic [N-1:0]           mem_rdata,
   output logic [N-1:0]           instruction,
   output logic [N-1:0]           inst_pc,
   output logic                   inst_valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t   state;
   logic [N-1:0]   fetch_ptr;
   logic           push;
   logic           pop;
   logic           room;
   logic [2*N-1:0] head;

   assign room       = count < CW'(DEPTH);
   assign inst_valid = count != '0;
   assign push       = (state == FETCH) && mem_ack && !redirect;
   assign pop        = inst_valid && !stall && !redirect;

   fetch_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .flush    (redirect),
      .data_in  ({mem_addr, mem_rdata}),
      .data_out (head),
      .count    (count)
   );

   assign inst_pc     = inst_valid ? head[2*N-1:N] : '0;
   assign instruction = inst_valid ? head[N-1:0] : N'(NOP);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         fetch_ptr <= N'(RESET_VECTOR);
         mem_req   <= 1'b0;
         mem_addr  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (redirect) begin
                  fetch_ptr <= redirect_addr;
               end else if (room) begin
                  state    <= FETCH;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_ptr;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  fetch_ptr <= redirect ? redirect_addr
                                        : mem_addr + N'(INST_STEP);
               end else if (redirect) begin
                  state     <= DRAIN;
                  fetch_ptr <= redirect_addr;
               end
            end
            // Stale response still owed; keep the port busy until it lands.
            DRAIN: begin
               if (redirect)
                  fetch_ptr <= redirect_addr;
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_inst_fetch_queue;
   import asip_fetch_pkg::*;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        stall = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] instruction;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic [2:0]  count;

   int vectors = 0;
   int miscompares = 0;

   inst_fetch_queue #(.N(32), .DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .stall         (stall),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .instruction   (instruction),
      .inst_pc       (inst_pc),
      .inst_valid    (inst_valid),
      .count         (count)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic        rd;
      logic [31:0] ra;
      logic        st;
      logic        ak;
      logic [31:0] rdt;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic        drn;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   vec_t tbl[22];

   // Model state
   ent_t        mq[$];
   bit          m_busy;
   bit          m_stale;
   logic [31:0] m_addr;
   logic [31:0] m_fptr;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic vec_t mk(
      input logic rd, input logic [31:0] ra, input logic st,
      input logic ak, input logic [31:0] rdt, input logic req,
      input logic [31:0] addr, input logic vld,
      input logic [31:0] ins, input logic [31:0] pc,
      input logic [2:0] cnt, input logic drn);
      vec_t v;
      v.rd = rd; v.ra = ra; v.st = st; v.ak = ak; v.rdt = rdt;
      v.req = req; v.addr = addr; v.vld = vld; v.ins = ins;
      v.pc = pc; v.cnt = cnt; v.drn = drn;
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      redirect = 1'b0;
      mem_ack = 1'b0;
      stall = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy = 0;
      m_stale = 0;
      m_addr = '0;
      m_fptr = '0;
   endtask

   // One clock of the reference model, applied to the inputs
   // presented during the cycle that is about to end.
   task automatic model_step();
      int  sz;
      bit  start;
      sz = mq.size();
      if (redirect) begin
         mq.delete();
         m_fptr = redirect_addr;
         if (m_busy && mem_ack) begin
            m_busy = 0;
            m_stale = 0;
         end else if (m_busy) begin
            m_stale = 1;
         end
      end else begin
         start = !m_busy && sz < DEPTH;
         if (sz > 0 && !stall)
            void'(mq.pop_front());
         if (m_busy && mem_ack) begin
            if (!m_stale) begin
               mq.push_back('{m_addr, mem_rdata});
               m_fptr = m_addr + 32'd4;
            end
            m_busy = 0;
            m_stale = 0;
         end else if (start) begin
            m_busy = 1;
            m_addr = m_fptr;
         end
      end
   endtask

   task automatic model_check();
      int sz;
      sz = mq.size();
      chk("r_req", 32'(mem_req), 32'(m_busy));
      chk("r_addr", mem_addr, m_addr);
      chk("r_valid", 32'(inst_valid), 32'(sz > 0));
      chk("r_inst", instruction, sz > 0 ? mq[0].inst : 32'h0);
      chk("r_pc", inst_pc, sz > 0 ? mq[0].pc : 32'h0);
      chk("r_count", 32'(count), 32'(sz));
   endtask

   initial begin
      logic [31:0] a[8];
      int n;
      int pct;
      for (int i = 0; i < 8; i++)
         a[i] = 32'hA000_0000 + 32'(i * 17);

      //       rd ra       st ak rdt  req addr     vld ins  pc       cnt drn
      tbl[0]  = mk(0, 0,       0, 0, 0,    1, 0,       0, 0,    0,       0, 0);
      tbl[1]  = mk(0, 0,       0, 0, 0,    1, 0,       0, 0,    0,       0, 0);
      tbl[2]  = mk(0, 0,       0, 1, a[0], 0, 0,       1, a[0], 0,       1, 0);
      tbl[3]  = mk(0, 0,       0, 0, 0,    1, 4,       0, 0,    0,       0, 0);
      tbl[4]  = mk(0, 0,       0, 0, 0,    1, 4,       0, 0,    0,       0, 0);
      tbl[5]  = mk(0, 0,       0, 1, a[1], 0, 4,       1, a[1], 4,       1, 0);
      tbl[6]  = mk(0, 0,       0, 0, 0,    1, 8,       0, 0,    0,       0, 0);
      tbl[7]  = mk(0, 0,       0, 0, 0,    1, 8,       0, 0,    0,       0, 0);
      tbl[8]  = mk(0, 0,       0, 1, a[2], 0, 8,       1, a[2], 8,       1, 0);
      tbl[9]  = mk(0, 0,       1, 0, 0,    1, 12,      1, a[2], 8,       1, 0);
      tbl[10] = mk(0, 0,       1, 1, a[3], 0, 12,      1, a[2], 8,       2, 0);
      tbl[11] = mk(0, 0,       0, 0, 0,    1, 16,      1, a[3], 12,      1, 0);
      tbl[12] = mk(0, 0,       0, 1, a[4], 0, 16,      1, a[4], 16,      1, 0);
      tbl[13] = mk(0, 0,       1, 0, 0,    1, 20,      1, a[4], 16,      1, 0);
      tbl[14] = mk(1, 'h40,    1, 1, a[5], 0, 20,      0, 0,    0,       0, 0);
      tbl[15] = mk(0, 0,       1, 0, 0,    1, 'h40,    0, 0,    0,       0, 0);
      tbl[16] = mk(1, 'h100,   1, 0, 0,    1, 'h40,    0, 0,    0,       0, 1);
      tbl[17] = mk(0, 0,       1, 0, 0,    1, 'h40,    0, 0,    0,       0, 1);
      tbl[18] = mk(0, 0,       1, 0, 0,    1, 'h40,    0, 0,    0,       0, 1);
      tbl[19] = mk(0, 0,       1, 1, a[6], 0, 'h40,    0, 0,    0,       0, 0);
      tbl[20] = mk(0, 0,       1, 0, 0,    1, 'h100,   0, 0,    0,       0, 0);
      tbl[21] = mk(0, 0,       1, 1, a[7], 0, 'h100,   1, a[7], 'h100,   1, 0);

      // Reset state
      @(negedge clock);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_valid", 32'(inst_valid), 0);
      chk("rst_inst", instruction, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_state", 32'(dut.state == IDLE), 1);

      // Directed table
      reset = 1'b1;
      for (int i = 0; i < 22; i++) begin
         redirect = tbl[i].rd;
         redirect_addr = tbl[i].ra;
         stall = tbl[i].st;
         mem_ack = tbl[i].ak;
         mem_rdata = tbl[i].rdt;
         @(negedge clock);
         chk($sformatf("t%0d_req", i), 32'(mem_req), 32'(tbl[i].req));
         chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].addr);
         chk($sformatf("t%0d_vld", i), 32'(inst_valid), 32'(tbl[i].vld));
         chk($sformatf("t%0d_ins", i), instruction, tbl[i].ins);
         chk($sformatf("t%0d_pc", i), inst_pc, tbl[i].pc);
         chk($sformatf("t%0d_cnt", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("t%0d_drain", i),
             32'(dut.state == DRAIN), 32'(tbl[i].drn));
      end
      redirect = 1'b0;
      mem_ack = 1'b0;

      // Stall held with zero-latency acks: queue fills, fetch pauses
      do_reset();
      stall = 1'b1;
      n = 0;
      while (count != 3'd4 && n < 40) begin
         mem_ack = mem_req;
         mem_rdata = word_of(mem_addr);
         @(negedge clock);
         n++;
      end
      chk("fill_count", 32'(count), 4);
      for (int i = 0; i < 3; i++) begin
         mem_ack = mem_req;
         @(negedge clock);
         chk("full_no_req", 32'(mem_req), 0);
      end
      mem_ack = 1'b0;
      stall = 1'b0;
      @(negedge clock);
      chk("pop_count", 32'(count), 3);
      chk("pop_head_pc", inst_pc, 4);
      chk("pop_head_inst", instruction, word_of(32'd4));
      stall = 1'b1;
      @(negedge clock);
      chk("refetch_req", 32'(mem_req), 1);
      chk("refetch_addr", mem_addr, 16);

      // Push and pop together at count 2
      do_reset();
      stall = 1'b1;
      n = 0;
      while (count != 3'd2 && n < 40) begin
         mem_ack = mem_req;
         mem_rdata = word_of(mem_addr);
         @(negedge clock);
         n++;
      end
      chk("pp_pre_count", 32'(count), 2);
      mem_ack = 1'b0;
      @(negedge clock);
      chk("pp_req", 32'(mem_req), 1);
      chk("pp_addr", mem_addr, 8);
      mem_ack = 1'b1;
      mem_rdata = word_of(32'd8);
      stall = 1'b0;
      @(negedge clock);
      chk("pp_count", 32'(count), 2);
      chk("pp_head_pc", inst_pc, 4);
      chk("pp_head_inst", instruction, word_of(32'd4));
      mem_ack = 1'b0;
      stall = 1'b1;
      @(negedge clock);
      chk("pp_next_req", 32'(mem_req), 1);
      chk("pp_next_addr", mem_addr, 12);

      // Asynchronous reset in the middle of a request
      #2 reset = 1'b0;
      #1;
      chk("async_req", 32'(mem_req), 0);
      chk("async_valid", 32'(inst_valid), 0);
      chk("async_count", 32'(count), 0);
      @(negedge clock);
      reset = 1'b1;
      stall = 1'b0;
      @(negedge clock);
      chk("post_rst_req", 32'(mem_req), 1);
      chk("post_rst_addr", mem_addr, 0);

      // Randomized run against the reference model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         model_check();
         pct = ((cyc / 250) % 2 == 1) ? 80 : 20;
         stall = ($urandom_range(0, 99) < pct);
         redirect = ($urandom_range(0, 19) == 0);
         redirect_addr = ($urandom_range(0, 7) == 0)
                         ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         mem_ack = m_busy && ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         model_step();
         @(negedge clock);
      end
      model_check();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
